// File: rtl/serial_rx_if.sv
// Frame output bundle of the serial receiver towards the frame consumer.
// Pure wiring, no latency of its own.
// No backpressure: the consumer must take frame_data while frame_valid is high.
interface serial_rx_if #(
    parameter int FRAME_WIDTH = 162
);
    logic [FRAME_WIDTH-1:0] frame_data;
    logic                   frame_valid;
    logic                   frame_error;
    logic                   busy;
    logic [4:0]             byte_count;

    // Receiver side drives the frame results.
    modport master (
        output frame_data,
        output frame_valid,
        output frame_error,
        output busy,
        output byte_count
    );

    // Consumer side observes them.
    modport slave (
        input frame_data,
        input frame_valid,
        input frame_error,
        input busy,
        input byte_count
    );
endinterface

// File: rtl/serial_rx.sv
// UART 8N1 receiver assembling NUM_BYTES LSB-first bytes into one frame; optional SERIAL_RX_MAJORITY_EN.
// Latency: frame_valid one cycle after the last stop-bit sample (2-flop sync + 1 cycle majority if enabled).
// No backpressure: frame_valid/frame_error are single-cycle pulses, frame_data holds until the next good frame.
module serial_rx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int NUM_BYTES    = 21,
    parameter int FRAME_WIDTH  = 162,
    parameter int TIMEOUT_BITS = 16
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        rx_pin,
    serial_rx_if.master rx_out
);
    localparam int SW  = NUM_BYTES * 8;
    localparam int TW  = $clog2(CLKS_PER_BIT);
    localparam int TOW = $clog2(TIMEOUT_BITS * CLKS_PER_BIT);
    localparam logic [TW-1:0]  BIT_END = TW'(CLKS_PER_BIT - 1);
    localparam logic [TOW-1:0] TO_END  = TOW'(TIMEOUT_BITS * CLKS_PER_BIT - 1);
`ifdef SERIAL_RX_MAJORITY_EN
    // Majority vote needs centre+1, so the start confirm lands one cycle later.
    localparam logic [TW-1:0]  START_PT = TW'(CLKS_PER_BIT / 2);
`else
    localparam logic [TW-1:0]  START_PT = TW'(CLKS_PER_BIT / 2 - 1);
`endif

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_IDLE} state_t;

    state_t                 state_q, state_d;
    logic                   sync1_q, sync1_d;
    logic                   rx_s_q, rx_s_d;
    logic                   rx_d1_q, rx_d1_d;
`ifdef SERIAL_RX_MAJORITY_EN
    logic                   rx_d2_q, rx_d2_d;
`endif
    logic [TW-1:0]          timer_q, timer_d;
    logic [2:0]             bit_idx_q, bit_idx_d;
    logic [SW-1:0]          shift_q, shift_d;
    logic [4:0]             byte_cnt_q, byte_cnt_d;
    logic [TOW-1:0]         idle_q, idle_d;
    logic [FRAME_WIDTH-1:0] frame_data_q, frame_data_d;
    logic                   frame_valid_q, frame_valid_d;
    logic                   frame_error_q, frame_error_d;
    logic                   busy_q, busy_d;
    logic                   samp;

    // Line sample used by start-confirm, data and stop decisions.
    always_comb begin
`ifdef SERIAL_RX_MAJORITY_EN
        samp = (rx_s_q & rx_d1_q) | (rx_s_q & rx_d2_q) | (rx_d1_q & rx_d2_q);
`else
        samp = rx_s_q;
`endif
    end

    // Next-state logic: synchronizer, bit timing, byte assembly, frame/timeout handling.
    always_comb begin
        state_d       = state_q;
        sync1_d       = rx_pin;
        rx_s_d        = sync1_q;
        rx_d1_d       = rx_s_q;
`ifdef SERIAL_RX_MAJORITY_EN
        rx_d2_d       = rx_d1_q;
`endif
        timer_d       = timer_q;
        bit_idx_d     = bit_idx_q;
        shift_d       = shift_q;
        byte_cnt_d    = byte_cnt_q;
        frame_data_d  = frame_data_q;
        frame_valid_d = 1'b0;
        frame_error_d = 1'b0;
        idle_d        = (state_q == IDLE && byte_cnt_q != 5'd0) ? idle_q + 1'b1 : '0;

        case (state_q)
            IDLE: begin
                timer_d = '0;
                if (byte_cnt_q != 5'd0 && idle_q == TO_END) begin
                    // Far end went quiet mid-frame: drop the partial frame.
                    frame_error_d = 1'b1;
                    byte_cnt_d    = 5'd0;
                    shift_d       = '0;
                    idle_d        = '0;
                end else if (!rx_s_q && rx_d1_q) begin
                    state_d = START;
                    idle_d  = '0;
                end
            end
            START: begin
                if (timer_q == START_PT) begin
                    timer_d   = '0;
                    bit_idx_d = 3'd0;
                    state_d   = samp ? IDLE : DATA;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            DATA: begin
                if (timer_q == BIT_END) begin
                    timer_d   = '0;
                    shift_d   = {samp, shift_q[SW-1:1]};
                    bit_idx_d = bit_idx_q + 1'b1;
                    if (bit_idx_q == 3'd7) state_d = STOP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            STOP: begin
                if (timer_q == BIT_END) begin
                    timer_d = '0;
                    if (samp) begin
                        state_d = IDLE;
                        if (byte_cnt_q == 5'(NUM_BYTES - 1)) begin
                            frame_data_d  = shift_q[FRAME_WIDTH-1:0];
                            frame_valid_d = 1'b1;
                            byte_cnt_d    = 5'd0;
                        end else begin
                            byte_cnt_d = byte_cnt_q + 5'd1;
                        end
                    end else begin
                        frame_error_d = 1'b1;
                        byte_cnt_d    = 5'd0;
                        shift_d       = '0;
                        state_d       = WAIT_IDLE;
                    end
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            WAIT_IDLE: begin
                // Requires one full high bit period before trusting edges again.
                if (!rx_s_q) begin
                    timer_d = '0;
                end else if (timer_q == BIT_END) begin
                    timer_d = '0;
                    state_d = IDLE;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase

        busy_d = (state_d != IDLE) || (byte_cnt_d != 5'd0);
    end

    // State and registered outputs; synchronizer idles high so reset never fakes a start edge.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= IDLE;
            sync1_q       <= 1'b1;
            rx_s_q        <= 1'b1;
            rx_d1_q       <= 1'b1;
`ifdef SERIAL_RX_MAJORITY_EN
            rx_d2_q       <= 1'b1;
`endif
            timer_q       <= '0;
            bit_idx_q     <= 3'd0;
            shift_q       <= '0;
            byte_cnt_q    <= 5'd0;
            idle_q        <= '0;
            frame_data_q  <= '0;
            frame_valid_q <= 1'b0;
            frame_error_q <= 1'b0;
            busy_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            rx_s_q        <= rx_s_d;
            rx_d1_q       <= rx_d1_d;
`ifdef SERIAL_RX_MAJORITY_EN
            rx_d2_q       <= rx_d2_d;
`endif
            timer_q       <= timer_d;
            bit_idx_q     <= bit_idx_d;
            shift_q       <= shift_d;
            byte_cnt_q    <= byte_cnt_d;
            idle_q        <= idle_d;
            frame_data_q  <= frame_data_d;
            frame_valid_q <= frame_valid_d;
            frame_error_q <= frame_error_d;
            busy_q        <= busy_d;
        end
    end

    assign rx_out.frame_data  = frame_data_q;
    assign rx_out.frame_valid = frame_valid_q;
    assign rx_out.frame_error = frame_error_q;
    assign rx_out.busy        = busy_q;
    assign rx_out.byte_count  = byte_cnt_q;
endmodule

// File: tb/tb_serial_rx.sv
// Bench for serial_rx: frames, glitch, framing error, timeout, reset abort, centre glitch.
// Expected frames/errors are queued when stimulus is sent and popped on each output pulse.
// Outputs are sampled 1 time unit after the rising edge or on the falling edge.
module tb_serial_rx;
    localparam int CPB = 16;
    localparam int NB  = 21;
    localparam int FW  = 162;
    localparam int TOB = 4;

    typedef struct packed {
        logic          is_err;
        logic [FW-1:0] data;
    } ev_t;

    logic clock   = 1'b0;
    logic reset_n = 1'b0;
    logic rx_pin  = 1'b1;

    serial_rx_if #(.FRAME_WIDTH(FW)) rx_if ();

    serial_rx #(
        .CLKS_PER_BIT(CPB),
        .NUM_BYTES   (NB),
        .FRAME_WIDTH (FW),
        .TIMEOUT_BITS(TOB)
    ) dut (
        .clock  (clock),
        .reset_n(reset_n),
        .rx_pin (rx_pin),
        .rx_out (rx_if)
    );

    always #5 clock = ~clock;

    ev_t           exp_q[$];
    ev_t           mon_e;
    int            n_chk = 0;
    int            n_err = 0;
    logic [FW-1:0] last_frame = '0;
    logic [FW-1:0] exp_f;
    logic          prev_v = 1'b0;
    logic          prev_e = 1'b0;

    task automatic check_val(input string tag, input logic [FW-1:0] got, input logic [FW-1:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [FW-1:0] frame_of(input logic [7:0] first);
        logic [NB*8-1:0] f;
        for (int k = 0; k < NB; k++) f[8*k +: 8] = first + 8'(k);
        return f[FW-1:0];
    endfunction

    // Output monitor: every pulse must match the oldest queued expectation.
    always @(posedge clock) begin
        #1;
        if (rx_if.frame_valid || rx_if.frame_error) begin
            check_val("exclusive", FW'(rx_if.frame_valid & rx_if.frame_error), '0);
            check_val("pulse_len", FW'({prev_v, prev_e}), '0);
            if (exp_q.size() == 0) begin
                check_val("unexpected_pulse", FW'({rx_if.frame_valid, rx_if.frame_error}), '0);
            end else begin
                mon_e = exp_q.pop_front();
                check_val("pulse_kind", FW'(rx_if.frame_error), FW'(mon_e.is_err));
                if (!mon_e.is_err) check_val("frame_data", rx_if.frame_data, mon_e.data);
            end
        end
        prev_v = rx_if.frame_valid;
        prev_e = rx_if.frame_error;
    end

    task automatic idle_cycles(input int n);
        repeat (n) @(negedge clock);
    endtask

    // One bit period; optional 1-cycle inversion exactly at the receiver's sample point.
    task automatic send_bit(input logic v, input bit glitch);
        rx_pin = v;
        if (!glitch) begin
            repeat (CPB) @(negedge clock);
        end else begin
            repeat (CPB / 2) @(negedge clock);
            rx_pin = ~v;
            @(negedge clock);
            rx_pin = v;
            repeat (CPB / 2 - 1) @(negedge clock);
        end
    endtask

    task automatic send_byte(input logic [7:0] b, input logic stop_v, input int gbit);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 8; i++) send_bit(b[i], i == gbit);
        send_bit(stop_v, 1'b0);
    endtask

    task automatic send_frame(input logic [7:0] first, input int gbyte, input int gbit);
        for (int k = 0; k < NB; k++) send_byte(first + 8'(k), 1'b1, (k == gbyte) ? gbit : -1);
    endtask

    task automatic push_ev(input logic is_err, input logic [FW-1:0] d);
        ev_t e;
        e.is_err = is_err;
        e.data   = d;
        exp_q.push_back(e);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        // Reset state
        repeat (3) @(negedge clock);
        check_val("rst_byte_count", FW'(rx_if.byte_count), '0);
        check_val("rst_busy", FW'(rx_if.busy), '0);
        check_val("rst_pulses", FW'({rx_if.frame_valid, rx_if.frame_error}), '0);
        check_val("rst_frame_data", rx_if.frame_data, '0);
        reset_n = 1'b1;
        idle_cycles(5);

        // Full frame 0x01..0x15
        last_frame = frame_of(8'h01);
        push_ev(1'b0, last_frame);
        send_frame(8'h01, -1, -1);
        idle_cycles(40);
        check_val("t1_pending", FW'(exp_q.size()), '0);
        check_val("t1_byte0", FW'(rx_if.frame_data[7:0]), FW'(8'h01));
        check_val("t1_byte1", FW'(rx_if.frame_data[15:8]), FW'(8'h02));
        check_val("t1_top", FW'(rx_if.frame_data[161:160]), FW'(2'b01));

        // Short low glitch is a false start
        rx_pin = 1'b0;
        repeat (4) @(negedge clock);
        rx_pin = 1'b1;
        check_val("t2_busy_in_start", FW'(rx_if.busy), FW'(1'b1));
        idle_cycles(30);
        check_val("t2_busy", FW'(rx_if.busy), '0);
        check_val("t2_byte_count", FW'(rx_if.byte_count), '0);

        // Framing error on byte 5, then a clean frame
        for (int k = 0; k < 4; k++) send_byte(8'h10 + 8'(k), 1'b1, -1);
        check_val("t3_byte_count4", FW'(rx_if.byte_count), FW'(5'd4));
        push_ev(1'b1, '0);
        send_byte(8'h14, 1'b0, -1);
        check_val("t3_byte_count", FW'(rx_if.byte_count), '0);
        check_val("t3_frame_hold", rx_if.frame_data, last_frame);
        check_val("t3_pending", FW'(exp_q.size()), '0);
        rx_pin = 1'b1;
        idle_cycles(40);
        last_frame = frame_of(8'h40);
        push_ev(1'b0, last_frame);
        send_frame(8'h40, -1, -1);
        idle_cycles(40);
        check_val("t3_after_pending", FW'(exp_q.size()), '0);

        // Inter-byte timeout after 10 bytes
        push_ev(1'b1, '0);
        for (int k = 0; k < 10; k++) send_byte(8'h80 + 8'(k), 1'b1, -1);
        check_val("t4_byte_count10", FW'(rx_if.byte_count), FW'(5'd10));
        check_val("t4_busy_hi", FW'(rx_if.busy), FW'(1'b1));
        idle_cycles(40);
        check_val("t4_early_count", FW'(rx_if.byte_count), FW'(5'd10));
        check_val("t4_early_pending", FW'(exp_q.size()), FW'(1));
        idle_cycles(70);
        check_val("t4_byte_count0", FW'(rx_if.byte_count), '0);
        check_val("t4_busy_lo", FW'(rx_if.busy), '0);
        check_val("t4_pending", FW'(exp_q.size()), '0);
        check_val("t4_frame_hold", rx_if.frame_data, last_frame);

        // Reset in the middle of byte 3
        send_byte(8'h20, 1'b1, -1);
        send_byte(8'h21, 1'b1, -1);
        send_bit(1'b0, 1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1, 1'b0);
        reset_n = 1'b0;
        #1;
        check_val("t5_byte_count", FW'(rx_if.byte_count), '0);
        check_val("t5_busy", FW'(rx_if.busy), '0);
        check_val("t5_frame_data", rx_if.frame_data, '0);
        check_val("t5_pulses", FW'({rx_if.frame_valid, rx_if.frame_error}), '0);
        last_frame = '0;
        rx_pin = 1'b1;
        repeat (3) @(negedge clock);
        reset_n = 1'b1;
        idle_cycles(20);
        last_frame = frame_of(8'h30);
        push_ev(1'b0, last_frame);
        send_frame(8'h30, -1, -1);
        idle_cycles(40);
        check_val("t5_pending", FW'(exp_q.size()), '0);
        check_val("t5_frame_after", rx_if.frame_data, last_frame);

        // One-cycle glitch at the centre of bit 3 of the first byte
        exp_f = frame_of(8'h50);
`ifndef SERIAL_RX_MAJORITY_EN
        exp_f[3] = ~exp_f[3];
`endif
        last_frame = exp_f;
        push_ev(1'b0, exp_f);
        send_frame(8'h50, 0, 3);
        idle_cycles(40);
        check_val("t6_pending", FW'(exp_q.size()), '0);
        check_val("t6_byte0", FW'(rx_if.frame_data[7:0]), FW'(exp_f[7:0]));

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
